// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks the register file's spare read port from
// register 0 to NUM_REGS-1 and streams {index, value} over valid/ready.
// It only reads the register file; writes by the core stay visible until
// the moment each register is captured.
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data, out_index
// and out_valid stay stable until that transfer, unless abort or reset
// cancels the dump.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = (ADDR_W)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  // One bit wider than the address so the pointer never wraps on a full dump.
  logic [ADDR_W:0] ptr;
  logic            handshake;

  assign handshake = out_valid && out_ready;
  assign rd_addr   = ptr[ADDR_W-1:0];
  assign state_dbg = state;

  // Dump sequencer: every output is registered; abort always returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            ptr   <= '0;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            out_data  <= rd_data;
            out_index <= ptr[ADDR_W-1:0];
            ptr       <= ptr + PTR_ONE;
            out_valid <= 1'b1;
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (abort) begin
            // a word accepted in this same cycle still counts as delivered
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (handshake) begin
            if (out_index == LAST_IDX) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              // rd_addr already points at the next register
              out_data  <= rd_data;
              out_index <= ptr[ADDR_W-1:0];
              ptr       <= ptr + PTR_ONE;
            end
          end
        end

        S_DONE: begin
          // done is high for this single cycle; a start here is dropped
          state <= S_IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a register file model drives rd_data, a
// driver issues directed scenarios and pushes expected words, and a monitor
// pops and compares every accepted word against the expected queue.
module tb_regfile_dump_reader;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int W        = ADDR_W + DATA_W;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start     = 1'b0;
  logic              abort     = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;

  // register file model with a combinational read port
  logic [DATA_W-1:0] regs [NUM_REGS];
  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int passes   = 0;
  int done_cnt = 0;
  int word_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // expected words of one full dump; optionally with reg 20 patched mid-dump
  task automatic push_run(input logic patch20);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < NUM_REGS; i++) begin
      d = 32'hA000_0000 + 32'(i);
      if (patch20 && i == 20) d = 32'hDEAD_BEEF;
      exp_q.push_back({i[ADDR_W-1:0], d});
    end
  endtask

  task automatic preload();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hA000_0000 + 32'(i);
  endtask

  // pulse start for one cycle; returns just after the edge that sampled it
  task automatic start_dump();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // advance until out_index k is presented (bounded)
  task automatic wait_idx(input int k);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (out_valid && out_index == k[ADDR_W-1:0]) return;
    end
    checks++;
    $display("FAIL wait_idx_%0d: index never presented within 200 cycles", k);
  endtask

  // advance until done is high (bounded); cycles counts edges waited
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      cycles++;
      if (done) return;
    end
    checks++;
    $display("FAIL wait_done: no done pulse within 200 cycles");
  endtask

  initial begin
    fork
      // monitor: compare each accepted word, and check holds while stalled
      begin
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (done) done_cnt++;
            if (out_valid) begin
              if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL word_unexpected: got idx %0d data %0h, expected no word",
                         out_index, out_data);
              end else if (out_ready) begin
                check("word", {27'd0, out_index, out_data}, {27'd0, exp_q.pop_front()});
                word_cnt++;
              end else begin
                check("hold", {27'd0, out_index, out_data}, {27'd0, exp_q[0]});
              end
            end
          end
        end
      end

      // driver
      begin
        int cyc;
        int d0;
        int w0;
        preload();
        #12 rst_n = 1'b1;

        // reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);

        // full dump with out_ready held high
        out_ready = 1'b1;
        d0 = done_cnt; w0 = word_cnt;
        push_run(1'b0);
        start_dump();
        check("lat_c1_valid", 64'(out_valid), 64'd0);
        check("lat_c1_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("lat_c2_valid", 64'(out_valid), 64'd1);
        check("lat_c2_index", 64'(out_index), 64'd0);
        wait_done(cyc);
        check("run1_cycles", 64'(cyc + 2), 64'd34);
        @(posedge clk); #1;
        check("run1_done_low", 64'(done), 64'd0);
        check("run1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("run1_words", 64'(word_cnt - w0), 64'd32);

        // backpressure at index 7, core write at index 3, start at index 4
        d0 = done_cnt; w0 = word_cnt;
        push_run(1'b1);
        start_dump();
        wait_idx(3);
        regs[20] = 32'hDEAD_BEEF;
        wait_idx(4);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idx(7);
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_next_index", 64'(out_index), 64'd8);
        wait_done(cyc);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("done_start_idle", 64'(state_dbg), 64'd0);
        @(posedge clk); #1;
        check("done_start_no_queue", 64'(state_dbg), 64'd0);
        check("run2_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("run2_words", 64'(word_cnt - w0), 64'd32);
        regs[20] = 32'hA000_0014;

        // abort coinciding with the handshake of index 12
        d0 = done_cnt; w0 = word_cnt;
        push_run(1'b0);
        start_dump();
        wait_idx(12);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_q.delete();
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_state", 64'(state_dbg), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_words", 64'(word_cnt - w0), 64'd13);

        // restart after abort begins again at index 0
        d0 = done_cnt; w0 = word_cnt;
        push_run(1'b0);
        start_dump();
        @(posedge clk); #1;
        check("restart_index", 64'(out_index), 64'd0);
        wait_done(cyc);
        @(posedge clk); #1;
        check("restart_words", 64'(word_cnt - w0), 64'd32);

        // asynchronous reset at index 9
        push_run(1'b0);
        start_dump();
        wait_idx(9);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_index", 64'(out_index), 64'd0);
        check("arst_rd_addr", 64'(rd_addr), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        exp_q.delete();
        #9 rst_n = 1'b1;

        // start and abort together keep it idle
        @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
        check("sa_state", 64'(state_dbg), 64'd0);
        check("sa_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("sa_valid", 64'(out_valid), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
      end
    join_any
  end

endmodule
